// File: rtl/clock_gate_ctrl.sv
// Per-channel clock gating: OFF/WAKE/ON request FSM with idle auto-gating
// and a glitch-free latch-AND gate per channel.
module clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              test_pin,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] gate_en,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int MAXC = (WAKE_CYCLES > IDLE_CYCLES) ?
                        WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          lat;

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state <= OFF;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        OFF: begin
          if (ch_req[i]) begin
            state_nx = WAKE;
            cnt_nx   = '0;
          end
        end
        WAKE: begin
          if (cnt == WAKE_LAST) begin
            state_nx = ON;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ON: begin
          // activity wins over a timeout on the same edge
          if (ch_req[i] | ch_busy[i]) begin
            cnt_nx = '0;
          end else if (cnt == IDLE_LAST) begin
            state_nx = OFF;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = OFF;
          cnt_nx   = '0;
        end
      endcase
    end

    assign gate_en[i] = (state != OFF);
    assign ch_ack[i]  = (state == ON);

    // reset clears the latch unless test mode needs the clock
    always_latch begin
      if (!rst_n && !test_pin) begin
        lat <= 1'b0;
      end else if (!clk_in) begin
        lat <= gate_en[i] | test_pin;
      end
    end

    assign clk_out[i] = clk_in & lat;
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural channel model.
module tb_clock_gate_ctrl;

  localparam int N  = 4;
  localparam int WC = 2;
  localparam int IC = 16;

  logic         clk;
  logic         rst_n;
  logic         test_pin;
  logic [N-1:0] ch_req;
  logic [N-1:0] ch_busy;
  logic [N-1:0] ch_ack;
  logic [N-1:0] gate_en;
  logic [N-1:0] clk_out;

  clock_gate_ctrl #(
    .NUM_CH     (N),
    .WAKE_CYCLES(WC),
    .IDLE_CYCLES(IC)
  ) dut (
    .clk_in  (clk),
    .rst_n   (rst_n),
    .test_pin(test_pin),
    .ch_req  (ch_req),
    .ch_busy (ch_busy),
    .ch_ack  (ch_ack),
    .gate_en (gate_en),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0=gated, 1=waking, 2=running
  int           mode [N];
  int           woke [N];
  int           idle [N];
  logic [N-1:0] latch_exp;
  logic [N-1:0] last_hi;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_gate();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = (mode[i] != 0);
    return g;
  endfunction

  function automatic logic [N-1:0] m_ack();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = (mode[i] == 2);
    return a;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      woke[i] = 0;
      idle[i] = 0;
    end
  endtask

  task automatic m_edge();
    for (int i = 0; i < N; i++) begin
      case (mode[i])
        0: if (ch_req[i]) begin
          mode[i] = 1;
          woke[i] = 0;
        end
        1: begin
          woke[i]++;
          if (woke[i] == WC) begin
            mode[i] = 2;
            idle[i] = 0;
          end
        end
        default: begin
          if (ch_req[i] || ch_busy[i]) idle[i] = 0;
          else idle[i]++;
          if (idle[i] == IC) mode[i] = 0;
        end
      endcase
    end
  endtask

  // One clk_in cycle; inputs are changed by callers in the low phase.
  task automatic step(input bit drop_test);
    @(posedge clk);
    latch_exp = m_gate() | {N{test_pin}};
    m_edge();
    if (drop_test) begin
      #1 test_pin = 1'b0;
      #2;
    end else begin
      #3;
    end
    last_hi = clk_out;
    chk("gate_en", gate_en, m_gate());
    chk("ch_ack", ch_ack, m_ack());
    chk("clk_out_hi", clk_out, latch_exp);
    @(negedge clk);
    #2;
    chk("clk_out_lo", clk_out, '0);
  endtask

  task automatic count_off(input int ch, output int n);
    n = 0;
    while (gate_en[ch] && n < 60) begin
      step(1'b0);
      n++;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gate", gate_en, '0);
    chk("rst_ack", ch_ack, '0);
    chk("rst_clk", clk_out, '0);
    m_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int n;

  initial begin
    rst_n    = 1'b0;
    test_pin = 1'b0;
    ch_req   = '0;
    ch_busy  = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_gate", gate_en, '0);
    chk("reset_ack", ch_ack, '0);
    #3 chk("reset_clk", clk_out, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // reset then wake on channel 0
    ch_req = 4'b0001;
    step(1'b0);
    ch_req = '0;
    chk("wake_gate0", {31'd0, gate_en[0]}, 32'd1);
    chk("wake_ack0", {31'd0, ch_ack[0]}, 32'd0);
    step(1'b0);
    chk("first_hi", last_hi, 4'b0001);
    chk("ack_early", {31'd0, ch_ack[0]}, 32'd0);
    step(1'b0);
    chk("ack_on", {31'd0, ch_ack[0]}, 32'd1);

    // idle timeout
    count_off(0, n);
    chk("idle_len", n, 16);

    // busy keep-alive
    ch_req = 4'b0001;
    step(1'b0);
    ch_req = '0;
    step(1'b0);
    step(1'b0);
    for (int k = 0; k < 100; k++) begin
      ch_busy = (k % 10 == 0) ? 4'b0001 : 4'b0000;
      step(1'b0);
      chk("keep_alive", {31'd0, ch_ack[0]}, 32'd1);
    end
    ch_busy = '0;
    count_off(0, n);
    chk("busy_tail", n, 7);

    // busy on the would-be timeout edge
    ch_req = 4'b0001;
    step(1'b0);
    ch_req = '0;
    step(1'b0);
    step(1'b0);
    repeat (15) step(1'b0);
    ch_busy = 4'b0001;
    step(1'b0);
    ch_busy = '0;
    chk("boundary_on", {31'd0, ch_ack[0]}, 32'd1);
    count_off(0, n);
    chk("boundary_len", n, 16);

    // test override with all channels gated
    test_pin = 1'b1;
    step(1'b0);
    chk("test_hi", last_hi, 4'hf);
    chk("test_ack", ch_ack, 4'h0);
    step(1'b0);
    step(1'b1);
    chk("test_hold", last_hi, 4'hf);
    step(1'b0);
    chk("test_off", last_hi, 4'h0);

    // async reset while running, request held
    ch_req = 4'b0001;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("pre_rst_on", {31'd0, ch_ack[0]}, 32'd1);
    async_reset();
    step(1'b0);
    chk("rewake_gate", {31'd0, gate_en[0]}, 32'd1);
    chk("rewake_ack", {31'd0, ch_ack[0]}, 32'd0);
    ch_req = '0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        ch_req[i]  = ($urandom_range(0, 11) == 0);
        ch_busy[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 60) == 0) test_pin = ~test_pin;
      if ($urandom_range(0, 400) == 0) begin
        test_pin = 1'b0;
        async_reset();
      end else if (test_pin && $urandom_range(0, 3) == 0) begin
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of independently gated clock channels; legal range 1..32.
REQ-002 Parameter WAKE_CYCLES, default 2, clk_in cycles a channel spends in WAKE before acknowledging; legal minimum 1.
REQ-003 Parameter IDLE_CYCLES, default 16, consecutive idle clk_in cycles in ON before auto-gating; legal minimum 1.
REQ-004 clk_in  input  1  free-running source clock; the block's only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 test_pin  input  1  scan/test override; forces every clk_out to follow clk_in.
REQ-007 ch_req  input  NUM_CH  per-channel clock request, level-sensitive, synchronous to clk_in.
REQ-008 ch_busy  input  NUM_CH  per-channel activity flag; restarts that channel's idle count.
REQ-009 ch_ack  output  NUM_CH  per-channel flag; clock running and stable.
REQ-010 gate_en  output  NUM_CH  per-channel registered gate enable, before latching.
REQ-011 clk_out  output  NUM_CH  per-channel gated clock.

Function
REQ-012 Each channel has an independent FSM with states OFF, WAKE and ON, a counter, and a glitch-free latch-AND gate.
REQ-013 The counter width is $clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1) bits; the counter never wraps.
REQ-014 Gate latch: transparent while clk_in is low and holds while clk_in is high; it captures gate_en[i] | test_pin.
REQ-015 Gate output: clk_out[i] = clk_in AND the latch output; no partial or runt high phase is produced during normal operation.
REQ-016 OFF: gate_en=0 and ch_ack=0; when ch_req[i] is sampled 1, go to WAKE, set gate_en=1 on the same edge, and clear the counter.
REQ-017 WAKE: gate_en=1 and ch_ack=0; the counter increments each cycle.
REQ-018 WAKE exit: after WAKE_CYCLES cycles in WAKE, go to ON with ch_ack=1; WAKE is not aborted if ch_req drops.
REQ-019 ON: gate_en=1 and ch_ack=1; a cycle with ch_req[i]|ch_busy[i] clears the counter; otherwise the counter increments.
REQ-020 ON exit: when the counter reaches IDLE_CYCLES (IDLE_CYCLES consecutive idle cycles), go to OFF, clearing gate_en and ch_ack on the same edge.
REQ-021 Simultaneous events: if ch_req or ch_busy is high on the cycle the count would hit IDLE_CYCLES, the channel stays ON and the counter clears.
REQ-022 Re-request from OFF: ch_req high in the first OFF cycle re-enters WAKE on the next edge; there is no minimum off time.
REQ-023 Latency from OFF: ch_req sampled at edge t gives gate_en=1 after edge t, the first clk_out high phase at edge t+1, and ch_ack=1 after edge t+WAKE_CYCLES.
REQ-024 test_pin=1 makes every clk_out follow clk_in (through the latch); the FSMs, ch_ack and gate_en keep operating unaffected.
REQ-025 ch_busy is ignored in OFF and WAKE.
REQ-026 Channels share no state; any mix of simultaneous requests is legal.

Reset
REQ-027 When rst_n=0, every FSM goes to OFF asynchronously, and all counters, gate_en and ch_ack go to 0.
REQ-028 When rst_n=0, the latch is cleared asynchronously, so clk_out=0 unless test_pin=1.
REQ-029 Truncating a clk_out high phase at reset assertion is acceptable.
REQ-030 Reset deassertion is synchronous to clk_in by the integrator; the first evaluated edge after deassertion sees the OFF state.
REQ-031 Reset mid-WAKE or mid-ON discards progress; after release, a channel needs a fresh ch_req.

Verification
REQ-032 Reset then wake: NUM_CH=4, WAKE_CYCLES=2; rst_n low, then high; ch_req=4'b0001 at edge 0 -> gate_en[0]=1 after edge 0, clk_out[0] first high at edge 1, ch_ack[0]=1 after edge 2, and channels 1..3 clk_out stay 0.
REQ-033 Idle timeout: IDLE_CYCLES=16; channel 0 in ON with ch_req=0 and ch_busy=0 -> gate_en[0] and ch_ack[0] fall after exactly 16 edges, and the last clk_out[0] high phase is complete (no glitch).
REQ-034 Busy keep-alive: in ON, pulse ch_busy[0] every 10 cycles for 100 cycles -> the channel stays ON throughout; after the final pulse it gates off after 16 idle cycles.
REQ-035 Boundary: ch_busy[0]=1 on idle count 15->16 -> the channel stays ON and the counter reads 0; separately, ch_req drops in WAKE -> ON is still reached, then idles out.
REQ-036 Test override: test_pin=1 with all channels OFF -> all 4 clk_out toggle with clk_in while ch_ack=0; deasserting test_pin while clk_in is high -> clk_out low from the next low phase, with no runt pulse.
REQ-037 Async reset mid-ON: rst_n low while clk_in is high -> clk_out, gate_en and ch_ack go to 0 immediately; after release with ch_req held at 1, WAKE restarts.
